// File: rtl/ram_arb_pkg.sv
// Shared definitions for the RAM port arbiter: default sizes, FSM state and command word.
package ram_arb_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_ADDR_WIDTH = 3;
  localparam int unsigned DEF_DEPTH      = 8;
  localparam int unsigned DEF_NUM_REQ    = 4;
  localparam int unsigned DEF_ID_WIDTH   = 2;

  typedef enum logic [0:0] {
    ARB  = 1'b0,
    INIT = 1'b1
  } arb_state_e;

  // Command held in the RAM-facing register; sized by the package defaults.
  typedef struct packed {
    logic                      wr;
    logic [DEF_ADDR_WIDTH-1:0] addr;
    logic [DEF_DATA_WIDTH-1:0] data;
    logic [DEF_ID_WIDTH-1:0]   id;
  } cmd_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, with wrap.
module rr_arbiter #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned ID_WIDTH = 2
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [ID_WIDTH-1:0] ptr,
  output logic [NUM_REQ-1:0]  grant,
  output logic [ID_WIDTH-1:0] grant_idx,
  output logic                grant_valid
);

  // Walk the requests starting at ptr; the first hit wins.
  always_comb begin
    int unsigned j;
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    j           = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      j = (32'(ptr) + k) % NUM_REQ;
      if (!grant_valid && req[j]) begin
        grant[j]    = 1'b1;
        grant_idx   = ID_WIDTH'(j);
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one synchronous RAM port among NUM_REQ requesters with round-robin grant,
// ID-tagged read responses and an INIT fill sweep.
// Optional: define RAM_ARB_PERF_EN to add grant_cnt / conflict_cnt performance counters.
// Parameters must match the ram_arb_pkg defaults, which size the command register.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = ram_arb_pkg::DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = ram_arb_pkg::DEF_ADDR_WIDTH,
  parameter int unsigned DEPTH      = ram_arb_pkg::DEF_DEPTH,
  parameter int unsigned NUM_REQ    = ram_arb_pkg::DEF_NUM_REQ,
  parameter int unsigned ID_WIDTH   = ram_arb_pkg::DEF_ID_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            req_wr,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic                          rsp_valid,
  output logic [ID_WIDTH-1:0]           rsp_id,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  input  logic                          init_start,
  input  logic [DATA_WIDTH-1:0]         init_value,
  output logic                          init_busy,
  output logic [ADDR_WIDTH-1:0]         ram_addr,
  output logic [DATA_WIDTH-1:0]         ram_din,
  output logic                          ram_wre,
  output logic                          ram_chipe,
  output logic                          ram_nrst,
  input  logic [DATA_WIDTH-1:0]         ram_dout
`ifdef RAM_ARB_PERF_EN
  ,
  output logic [NUM_REQ*16-1:0]         grant_cnt,
  output logic [15:0]                   conflict_cnt
`endif
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ID_WIDTH-1:0]   LAST_ID   = ID_WIDTH'(NUM_REQ - 1);

  arb_state_e                state_q, state_d;
  logic [ID_WIDTH-1:0]       ptr_q, ptr_d;
  logic [ADDR_WIDTH-1:0]     init_cnt_q, init_cnt_d;
  logic [DATA_WIDTH-1:0]     init_val_q, init_val_d;
  cmd_t                      cmd_q, cmd_d;
  logic                      chipe_q, chipe_d;
  logic                      rsp_valid_q;
  logic [ID_WIDTH-1:0]       rsp_id_q;
  logic                      nrst_q;

  logic [NUM_REQ-1:0]        grant;
  logic [ID_WIDTH-1:0]       gidx;
  logic                      gvalid;
  logic                      arb_en;
  logic                      accept;
  logic                      stage1_rd;

  rr_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_rr (
    .req         (req_valid),
    .ptr         (ptr_q),
    .grant       (grant),
    .grant_idx   (gidx),
    .grant_valid (gvalid)
  );

  // init_start outranks any request in the same cycle.
  assign arb_en    = (state_q == ARB) && !init_start;
  assign req_ready = arb_en ? grant : '0;
  assign accept    = arb_en && gvalid;

  // FSM next state, pointer, sweep counter and fill value.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    init_cnt_d = init_cnt_q;
    init_val_d = init_val_q;
    unique case (state_q)
      ARB: begin
        if (init_start) begin
          state_d    = INIT;
          init_cnt_d = '0;
          init_val_d = init_value;
        end else if (accept) begin
          ptr_d = (gidx == LAST_ID) ? '0 : gidx + 1'b1;
        end
      end
      INIT: begin
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == LAST_ADDR) state_d = ARB;
      end
      default: state_d = ARB;
    endcase
  end

  // Next command for the RAM port: sweep write, granted request, or idle.
  always_comb begin
    cmd_d   = cmd_q;
    chipe_d = 1'b0;
    if (state_q == INIT) begin
      cmd_d.wr   = 1'b1;
      cmd_d.addr = init_cnt_q;
      cmd_d.data = init_val_q;
      chipe_d    = 1'b1;
    end else if (accept) begin
      cmd_d.wr   = req_wr[gidx];
      cmd_d.addr = req_addr[32'(gidx)*ADDR_WIDTH +: ADDR_WIDTH];
      cmd_d.data = req_wdata[32'(gidx)*DATA_WIDTH +: DATA_WIDTH];
      cmd_d.id   = gidx;
      chipe_d    = 1'b1;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ARB;
      ptr_q      <= '0;
      init_cnt_q <= '0;
      init_val_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      init_cnt_q <= init_cnt_d;
      init_val_q <= init_val_d;
    end
  end

  // RAM command register; doubles as the first stage of the read-ID pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_q   <= '0;
      chipe_q <= 1'b0;
    end else begin
      cmd_q   <= cmd_d;
      chipe_q <= chipe_d;
    end
  end

  assign stage1_rd = chipe_q && !cmd_q.wr;

  // Second pipeline stage lines up with the RAM's registered read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
    end else begin
      rsp_valid_q <= stage1_rd;
      if (stage1_rd) rsp_id_q <= cmd_q.id;
    end
  end

  // RAM reset release is registered so it follows rst by one edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) nrst_q <= 1'b0;
    else     nrst_q <= 1'b1;
  end

  assign ram_addr  = cmd_q.addr;
  assign ram_din   = cmd_q.data;
  assign ram_chipe = chipe_q;
  assign ram_wre   = chipe_q & cmd_q.wr;
  assign ram_nrst  = nrst_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = ram_dout;
  assign init_busy = (state_q == INIT);

`ifdef RAM_ARB_PERF_EN
  logic [15:0] grant_cnt_q [NUM_REQ];
  logic [15:0] conflict_q;

  // Saturating per-requester grant counts and multi-request conflict count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) grant_cnt_q[i] <= '0;
      conflict_q <= '0;
    end else begin
      if (accept && grant_cnt_q[gidx] != 16'hffff) begin
        grant_cnt_q[gidx] <= grant_cnt_q[gidx] + 16'd1;
      end
      if (state_q == ARB && $countones(req_valid) >= 2 && conflict_q != 16'hffff) begin
        conflict_q <= conflict_q + 16'd1;
      end
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt_out
    assign grant_cnt[g*16 +: 16] = grant_cnt_q[g];
  end
  assign conflict_cnt = conflict_q;
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: behavioural RAM, reference arbiter model and
// a response scoreboard. Covers RAM_ARB_PERF_EN counters when that macro is defined.
module tb_ram_port_arbiter;

  localparam int DW = 8;
  localparam int AW = 3;
  localparam int DEPTH = 8;
  localparam int NR = 4;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req_valid, req_ready, req_wr;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic            rsp_valid;
  logic [IW-1:0]   rsp_id;
  logic [DW-1:0]   rsp_data;
  logic            init_start;
  logic [DW-1:0]   init_value;
  logic            init_busy;
  logic [AW-1:0]   ram_addr;
  logic [DW-1:0]   ram_din;
  logic            ram_wre, ram_chipe, ram_nrst;
  logic [DW-1:0]   ram_dout;
`ifdef RAM_ARB_PERF_EN
  logic [NR*16-1:0] grant_cnt;
  logic [15:0]      conflict_cnt;
`endif

  always #5 clk = ~clk;

  ram_port_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_wr     (req_wr),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .init_start (init_start),
    .init_value (init_value),
    .init_busy  (init_busy),
    .ram_addr   (ram_addr),
    .ram_din    (ram_din),
    .ram_wre    (ram_wre),
    .ram_chipe  (ram_chipe),
    .ram_nrst   (ram_nrst),
    .ram_dout   (ram_dout)
`ifdef RAM_ARB_PERF_EN
    ,
    .grant_cnt    (grant_cnt),
    .conflict_cnt (conflict_cnt)
`endif
  );

  // Behavioural synchronous RAM, one-cycle registered read.
  logic [DW-1:0] mem [2**AW];
  initial begin
    for (int i = 0; i < 2**AW; i++) mem[i] = '0;
    ram_dout = '0;
  end
  always @(posedge clk) begin
    if (ram_chipe) begin
      if (ram_wre) mem[ram_addr] <= ram_din;
      else         ram_dout <= mem[ram_addr];
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [IW-1:0] id;
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t          sb[$];
  int            acc_log[$];
  logic [DW-1:0] shadow [2**AW];
  int            cyc = 0;
  int            rsp_cnt = 0;
  int            m_ptr = 0;
  bit            m_busy = 0;
  int            m_cnt = 0;
  logic [DW-1:0] m_fill = '0;
  bit            exp_chipe = 0, exp_wre = 0;
  logic [AW-1:0] exp_addr = '0;
  logic [DW-1:0] exp_din = '0;
  int            m_grants [NR];
  int            m_conflict = 0;
  bit            nrst_exp;

  initial for (int i = 0; i < 2**AW; i++) shadow[i] = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) nrst_exp <= 1'b0;
    else     nrst_exp <= 1'b1;
  end

  // Reference model and scoreboard, sampled mid-cycle on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      check("rst_chipe", ram_chipe, 0);
      check("rst_wre", ram_wre, 0);
      check("rst_addr", ram_addr, 0);
      check("rst_din", ram_din, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_id", rsp_id, 0);
      check("rst_busy", init_busy, 0);
      check("rst_nrst", ram_nrst, 0);
      sb.delete();
      m_ptr = 0; m_busy = 0; m_cnt = 0;
      exp_chipe = 0; exp_wre = 0; exp_addr = '0; exp_din = '0;
      for (int i = 0; i < NR; i++) m_grants[i] = 0;
      m_conflict = 0;
    end else begin
      logic [NR-1:0] exp_rdy;
      int g;
      bit found;
      check("nrst", ram_nrst, nrst_exp);
      check("ram_chipe", ram_chipe, exp_chipe);
      check("ram_wre", ram_wre, exp_wre);
      if (exp_chipe) begin
        check("ram_addr", ram_addr, exp_addr);
        check("ram_din", ram_din, exp_din);
      end
      if (rsp_valid) begin
        rsp_cnt++;
        if (sb.size() == 0) begin
          check("rsp_unexpected", rsp_valid, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("rsp_id", rsp_id, e.id);
          check("rsp_data", rsp_data, e.data);
          check("rsp_latency", cyc, e.due);
        end
      end else if (sb.size() != 0 && sb[0].due <= cyc) begin
        check("rsp_missing", rsp_valid, 1);
        void'(sb.pop_front());
      end
      check("init_busy", init_busy, m_busy);
      found = 0; g = 0; exp_rdy = '0;
      if (!m_busy && !init_start) begin
        for (int k = 0; k < NR; k++) begin
          int j;
          j = (m_ptr + k) % NR;
          if (!found && req_valid[j]) begin found = 1; g = j; end
        end
        if (found) exp_rdy[g] = 1'b1;
      end
      check("req_ready", req_ready, exp_rdy);
      if (!m_busy && $countones(req_valid) >= 2) m_conflict++;
      if (m_busy) begin
        exp_chipe = 1; exp_wre = 1;
        exp_addr = AW'(m_cnt); exp_din = m_fill;
        shadow[m_cnt] = m_fill;
        if (m_cnt == DEPTH - 1) m_busy = 0;
        m_cnt++;
      end else if (init_start) begin
        m_busy = 1; m_cnt = 0; m_fill = init_value;
        exp_chipe = 0; exp_wre = 0;
      end else if (found) begin
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        a = req_addr[g*AW +: AW];
        d = req_wdata[g*DW +: DW];
        exp_chipe = 1; exp_wre = req_wr[g]; exp_addr = a; exp_din = d;
        if (req_wr[g]) shadow[a] = d;
        else sb.push_back('{id: IW'(g), data: shadow[a], due: cyc + 2});
        acc_log.push_back(g);
        m_grants[g]++;
        m_ptr = (g + 1) % NR;
      end else begin
        exp_chipe = 0; exp_wre = 0;
      end
    end
    cyc++;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    req_valid = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
  endtask

  task automatic set_req(input int i, input bit wr, input int addr, input int data);
    req_valid[i] = 1'b1;
    req_wr[i] = wr;
    req_addr[i*AW +: AW] = AW'(addr);
    req_wdata[i*DW +: DW] = DW'(data);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    step(1);
    rst = 1'b0;
  endtask

  initial begin
    int base;
    int busy_cycles;
    bit seen;
    rst = 1'b1;
    init_start = 1'b0; init_value = '0;
    clear_reqs();
    step(2);
    rst = 1'b0;
    step(1);

    // Write then read back through a different requester.
    base = rsp_cnt;
    set_req(0, 1, 3, 8'h5a); step(1); clear_reqs();
    set_req(2, 0, 3, 0);     step(1); clear_reqs();
    for (int k = 0; k < 3; k++) begin
      set_req(1, 1, k, 8'h10 + k); step(1); clear_reqs();
    end
    step(4);
    check("t1_rsp_count", rsp_cnt - base, 1);

    // All four requesters reading continuously from pointer 0.
    do_reset();
    acc_log.delete();
    base = rsp_cnt;
    for (int i = 0; i < NR; i++) set_req(i, 0, i, 0);
    step(8); clear_reqs(); step(4);
    check("t2_grants", acc_log.size(), 8);
    for (int k = 0; k < 8 && k < acc_log.size(); k++) check("t2_order", acc_log[k], k % NR);
    check("t2_rsp_count", rsp_cnt - base, 8);

    // Lone requester, then pointer wrap.
    acc_log.delete();
    set_req(1, 0, 1, 0); step(3);
    set_req(0, 0, 0, 0); step(1); clear_reqs(); step(3);
    check("t3_grants", acc_log.size(), 4);
    if (acc_log.size() == 4) begin
      check("t3_g0", acc_log[0], 1);
      check("t3_g1", acc_log[1], 1);
      check("t3_g2", acc_log[2], 1);
      check("t3_wrap", acc_log[3], 0);
    end

    // INIT sweep with a read in flight and a request waiting.
    set_req(1, 0, 6, 0); step(1); clear_reqs();
    init_start = 1'b1; init_value = 8'hff;
    set_req(3, 0, 5, 0);
    step(1);
    init_start = 1'b0;
    busy_cycles = 0; seen = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (init_busy) begin busy_cycles++; seen = 1; end
      else if (seen) break;
    end
    @(posedge clk); #1 clear_reqs();
    step(4);
    check("t4_busy_len", busy_cycles, DEPTH);
    check("t4_mem5", mem[5], 8'hff);

    // Reset between accept and response drops the read.
    base = rsp_cnt;
    set_req(2, 0, 5, 0); step(1); clear_reqs();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(4);
    check("t5_dropped", rsp_cnt - base, 0);

`ifdef RAM_ARB_PERF_EN
    set_req(0, 0, 0, 0); set_req(1, 0, 1, 0); step(2); clear_reqs();
    set_req(0, 0, 2, 0); step(2); clear_reqs(); step(3);
    check("perf_conflict", conflict_cnt, 2);
    check("perf_grant0", grant_cnt[15:0], 3);
    check("perf_grant1", grant_cnt[31:16], 1);
    check("perf_conflict_model", conflict_cnt, m_conflict);
    for (int i = 0; i < NR; i++) check("perf_grant_model", grant_cnt[i*16 +: 16], m_grants[i]);
`endif

    for (int t = 0; t < 20 && sb.size() != 0; t++) step(1);
    check("drain", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares one synchronous RAM port (addr/din/wre/chipe/nrst/dout, 1-cycle registered read) among NUM_REQ requesters.
- Per-requester valid/ready handshake, round-robin grant, returned read data tagged with requester ID.
- Includes an INIT sequencer that sweeps a fill value into every RAM address on command, locking out requesters meanwhile.
- Sits between client logic and one port of the dual-port RAM; the other RAM port is untouched.

Parameters:
- DATA_WIDTH, 8, RAM word width
- ADDR_WIDTH, 3, RAM address width
- DEPTH, 8, RAM words swept by INIT (DEPTH <= 2**ADDR_WIDTH)
- NUM_REQ, 4, requester count (>= 2)
- ID_WIDTH, 2, requester ID width (= clog2(NUM_REQ))

Ports:
- clk  in  1  single clock, all logic on posedge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept, one-hot or zero
- req_wr  in  NUM_REQ  1=write, 0=read, per requester
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data
- rsp_valid  out  1  read data valid (no backpressure)
- rsp_id  out  ID_WIDTH  requester that issued the read
- rsp_data  out  DATA_WIDTH  read data
- init_start  in  1  pulse: start fill sweep
- init_value  in  DATA_WIDTH  fill word, sampled at init_start
- init_busy  out  1  high while sweeping
- ram_addr  out  ADDR_WIDTH  to RAM addr
- ram_din  out  DATA_WIDTH  to RAM data_in
- ram_wre  out  1  to RAM wre
- ram_chipe  out  1  to RAM chipe
- ram_nrst  out  1  to RAM nrst
- ram_dout  in  DATA_WIDTH  from RAM data_out

Behaviour:
- Reset values:
  - ram_chipe=0, ram_wre=0, ram_addr=0, ram_din=0.
  - rsp_valid=0, rsp_id=0, rsp_data tracks ram_dout.
  - init_busy=0, rr pointer=0, state=ARB.
  - ram_nrst=0 while rst is high, then 1 from the first posedge after rst deasserts (registered).
- FSM states: ARB, INIT.
  - ARB -> INIT on init_start=1 (init_start has priority over pending requests that cycle).
  - INIT -> ARB after the write to address DEPTH-1 issues.
  - init_start while in INIT is ignored.
- Arbitration (ARB only):
  - req_ready is combinational.
  - Grant goes to the first i with req_valid[i]=1, searching from the rr pointer upward with wrap.
  - At most one grant per cycle. req_ready=0 in INIT.
  - Acceptance means req_valid[i] && req_ready[i] at a posedge (edge E0). The pointer then becomes (i+1) mod NUM_REQ.
  - The pointer is unchanged when nothing is granted.
- Command issue:
  - At E0, registers load ram_addr, ram_din, ram_wre=req_wr[i], ram_chipe=1.
  - With no acceptance at an edge, ram_chipe=0 and ram_wre=0.
  - The RAM samples the command at E1.
- Read latency:
  - The ID pipeline delays (read, id) by 2 edges.
  - rsp_valid=1 in the cycle after E1, with rsp_data=ram_dout and rsp_id=i.
  - Total: accept at E0 -> rsp at E2-visible cycle.
  - Fully pipelined: back-to-back reads give back-to-back rsp.
- Writes give no response. A read accepted the cycle after a write to the same address returns the new data.
- INIT sweep:
  - init_busy=1 from the edge that accepts init_start.
  - Issues writes of init_value to addresses 0..DEPTH-1, one per cycle (ram_chipe=1, ram_wre=1).
  - init_busy drops on the edge after the DEPTH-1 write issues.
  - Reads in flight at init_start still complete with a response.
- Reset mid-operation: all in-flight reads are dropped (no rsp) and the INIT sweep is abandoned. RAM contents are undefined with respect to the sweep.
- Address width: no range check. Addresses >= DEPTH are forwarded unchanged.

Optional Feature:
- Macro RAM_ARB_PERF_EN.
- Defined:
  - Adds output grant_cnt (NUM_REQ*16), a per-requester 16-bit saturating count of accepted requests.
  - Adds output conflict_cnt (16), a saturating count of cycles with >=2 req_valid set in ARB.
  - Both counters clear on rst.
- Undefined: no counters, no extra ports.

Decomposition:
- Package ram_arb_pkg holds:
  - DATA_WIDTH, ADDR_WIDTH, DEPTH, NUM_REQ, ID_WIDTH defaults.
  - State enum arb_state_e {ARB, INIT}.
  - Command struct {wr, addr, data, id}.
- Sub-module rr_arbiter (NUM_REQ): req vector plus pointer in, one-hot grant plus grant index out, purely combinational. The pointer register stays in the parent.

Test Plan:
- Reset, then single read: write 0x5A to addr 3 via req 0, then read addr 3 via req 2 -> rsp_valid exactly 2 cycles after accept, rsp_id=2, rsp_data=0x5A.
- All 4 requesters hold req_valid reads for 8 cycles, pointer=0 -> grant order 0,1,2,3,0,1,2,3 and 8 consecutive rsp cycles with matching rsp_id.
- Only req 1 valid for 3 cycles -> 3 grants to req 1. Then req 0 and req 1 both valid -> req 0 granted (pointer=2 wraps to 0).
- init_start with init_value=0xFF while req 3 is valid -> req_ready=0 for 8 cycles, ram_addr walks 0..7 with ram_wre=1, init_busy drops; subsequent read of addr 5 returns 0xFF.
- Assert rst for 1 cycle between a read accept and its response -> no rsp_valid, all outputs at reset values, ram_nrst low during rst.
- RAM_ARB_PERF_EN: 2 conflicting cycles plus 3 grants to req 0 -> conflict_cnt=2, grant_cnt[0]=3.
